// File: rtl/uart_pkg.sv
// Shared UART transmitter definitions: FSM state encoding and line levels.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic IDLE_LVL  = 1'b1;
    localparam logic START_LVL = 1'b0;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1, wraps on bit_done, cleared by i_clear.
module uart_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    output logic o_bit_done
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_clk_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_cnt <= '0;
        end else if (i_clear || o_bit_done) begin
            r_clk_cnt <= '0;
        end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
        end
    end

    assign o_bit_done = (r_clk_cnt == LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames start/data/[parity]/stop and pulses the serializer shift.
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  Data_Valid,
    input  logic [DATA_WIDTH-1:0] P_Data,
    input  logic                  PAR_TYP,
    input  logic                  Serial_Data,
    output logic                  Ser_En,
    output logic                  Busy,
    output logic                  TX_OUT
);

    localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_WIDTH - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    tx_state_e      r_state;
    tx_state_e      w_next;
    logic [BCW-1:0] r_bit_cnt;
    logic           w_bit_done;
    logic           w_clear;

    // Timer restarts on every state change so each state begins on a fresh bit period.
    assign w_clear = (w_next != r_state);

    uart_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .i_clk     (CLK),
        .i_rst_n   (RST),
        .i_clear   (w_clear),
        .o_bit_done(w_bit_done)
    );

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_parity <= 1'b0;
        end else if ((r_state == IDLE) && Data_Valid) begin
            r_parity <= (^P_Data) ^ PAR_TYP;
        end
    end
`else
    logic w_unused;
    assign w_unused = ^{P_Data, PAR_TYP};
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (w_clear) begin
                r_bit_cnt <= '0;
            end else if (w_bit_done && ((r_state == DATA) || (r_state == STOP))) begin
                r_bit_cnt <= r_bit_cnt + BCW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        Ser_En = 1'b0;
        Busy   = 1'b1;
        TX_OUT = IDLE_LVL;
        case (r_state)
            IDLE: begin
                Busy = 1'b0;
                if (Data_Valid) w_next = START;
            end
            START: begin
                TX_OUT = START_LVL;
                if (w_bit_done) w_next = DATA;
            end
            DATA: begin
                TX_OUT = Serial_Data;
                if (w_bit_done) begin
                    Ser_En = 1'b1;
                    if (r_bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        w_next = PARITY;
`else
                        w_next = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                TX_OUT = r_parity;
                if (w_bit_done) w_next = STOP;
            end
`endif
            STOP: begin
                TX_OUT = IDLE_LVL;
                if (w_bit_done && (r_bit_cnt == LAST_STOP)) w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule
